// File: rtl/sramlike_arbiter.sv
// Two-to-one sram-like arbiter: merges the inst and data masters onto one slave port.
// Data has priority; a starvation counter forces inst through after STARVE_LIMIT data grants.
module sramlike_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;
  logic [3:0]  scnt_reg, scnt_next;
  logic        m_wr_reg, m_wr_next;
  logic [1:0]  m_size_reg, m_size_next;
  logic [31:0] m_addr_reg, m_addr_next;
  logic [31:0] m_wdata_reg, m_wdata_next;

  logic        inst_win;
  logic        ack_addr;
  logic        ack_data;
  logic [1:0]  addr_ok_vec;
  logic [1:0]  data_ok_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      scnt_reg    <= 4'd0;
      m_wr_reg    <= 1'b0;
      m_size_reg  <= 2'b00;
      m_addr_reg  <= 32'd0;
      m_wdata_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      scnt_reg    <= scnt_next;
      m_wr_reg    <= m_wr_next;
      m_size_reg  <= m_size_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    scnt_next    = scnt_reg;
    m_wr_next    = m_wr_reg;
    m_size_next  = m_size_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    inst_win     = 1'b0;
    ack_addr     = 1'b0;
    ack_data     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (inst_req | data_req) begin
          inst_win   = inst_req & (~data_req | (scnt_reg == LIMIT));
          grant_next = ~inst_win;
          state_next = ADDR;
          if (inst_win) begin
            m_wr_next    = inst_wr;
            m_size_next  = inst_size;
            m_addr_next  = inst_addr;
            m_wdata_next = inst_wdata;
            scnt_next    = 4'd0;
          end else begin
            m_wr_next    = data_wr;
            m_size_next  = data_size;
            m_addr_next  = data_addr;
            m_wdata_next = data_wdata;
            // Count only data grants that actually bypassed a waiting inst request.
            if (!inst_req)
              scnt_next = 4'd0;
            else if (scnt_reg >= LIMIT)
              scnt_next = LIMIT;
            else
              scnt_next = scnt_reg + 4'd1;
          end
        end
      end
      ADDR: begin
        // An early m_data_ok implies the address was taken too.
        if (m_addr_ok | m_data_ok) begin
          ack_addr = 1'b1;
          if (m_data_ok) begin
            ack_data   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (m_data_ok) begin
          ack_data   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Route handshakes only to the master selected by grant (0 inst, 1 data).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_route
      assign addr_ok_vec[gi] = ack_addr & (grant_reg == 1'(gi));
      assign data_ok_vec[gi] = ack_data & (grant_reg == 1'(gi));
    end
  endgenerate

  assign inst_addr_ok = addr_ok_vec[0];
  assign inst_data_ok = data_ok_vec[0];
  assign data_addr_ok = addr_ok_vec[1];
  assign data_data_ok = data_ok_vec[1];
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign m_req   = (state_reg == ADDR);
  assign m_wr    = m_wr_reg;
  assign m_size  = m_size_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: cycle vector table, then starvation order and mid-transaction reset.
module tb_sramlike_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sramlike_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  typedef struct {
    logic        rst, ireq, dreq, dwr;
    logic [1:0]  dsize;
    logic [31:0] iaddr, daddr, dwdata;
    logic        maok, mdok;
    logic [31:0] mrdata;
    logic        e_req, e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    logic        e_iaok, e_idok, e_daok, e_ddok;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [135:0] observed();
    return {m_req, m_wr, m_size, m_addr, m_wdata,
            inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
            inst_rdata, data_rdata};
  endfunction

  task automatic check(input string name, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s %h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [135:0] exp_b;
    logic         order[6];
    logic         want[6];
    int           got_n;

    //         rst ireq dreq dwr dsize iaddr         daddr         dwdata        maok mdok mrdata        req wr size addr          wdata         iaok idok daok ddok
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,2'd0,32'h0,     32'h0,     32'h0,     1'b0,1'b0,32'h0,        1'b0,1'b0,2'd0,32'h0,     32'h0,        1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,2'd2,32'h0,     32'h1000,  32'h0,     1'b0,1'b0,32'h0,        1'b0,1'b0,2'd0,32'h0,     32'h0,        1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,2'd2,32'h0,     32'h1000,  32'h0,     1'b1,1'b0,32'h0,        1'b1,1'b0,2'd2,32'h1000,  32'h0,        1'b0,1'b0,1'b1,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,2'd2,32'h0,     32'h1000,  32'h0,     1'b0,1'b0,32'h0,        1'b0,1'b0,2'd2,32'h1000,  32'h0,        1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,2'd2,32'h0,     32'h1000,  32'h0,     1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,2'd2,32'h1000,  32'h0,        1'b0,1'b0,1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,2'd2,32'h0,     32'h1000,  32'h0,     1'b0,1'b0,32'h0,        1'b0,1'b0,2'd2,32'h1000,  32'h0,        1'b0,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,2'd2,32'h4000,  32'h3000,  32'h0,     1'b0,1'b0,32'h0,        1'b0,1'b0,2'd2,32'h1000,  32'h0,        1'b0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,2'd2,32'h4000,  32'h3000,  32'h0,     1'b1,1'b1,32'hCAFE0001, 1'b1,1'b0,2'd2,32'h3000,  32'h0,        1'b0,1'b0,1'b1,1'b1};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,2'd2,32'h4000,  32'h3000,  32'h0,     1'b0,1'b0,32'h0,        1'b0,1'b0,2'd2,32'h3000,  32'h0,        1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,2'd2,32'h4000,  32'h3000,  32'h0,     1'b1,1'b1,32'h12345678, 1'b1,1'b0,2'd2,32'h4000,  32'h11111111, 1'b1,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,2'd2,32'h4000,  32'h3000,  32'h0,     1'b0,1'b0,32'h0,        1'b0,1'b0,2'd2,32'h4000,  32'h11111111, 1'b0,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b1,2'd1,32'h4000,  32'h2002,  32'hBEEF,  1'b0,1'b0,32'h0,        1'b0,1'b0,2'd2,32'h4000,  32'h11111111, 1'b0,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b1,2'd1,32'h4000,  32'h2002,  32'hBEEF,  1'b0,1'b0,32'h0,        1'b1,1'b1,2'd1,32'h2002,  32'hBEEF,     1'b0,1'b0,1'b0,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b1,2'd1,32'h4000,  32'h2002,  32'hBEEF,  1'b0,1'b0,32'h0,        1'b1,1'b1,2'd1,32'h2002,  32'hBEEF,     1'b0,1'b0,1'b0,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b1,1'b1,2'd1,32'h4000,  32'h2002,  32'hBEEF,  1'b1,1'b0,32'h0,        1'b1,1'b1,2'd1,32'h2002,  32'hBEEF,     1'b0,1'b0,1'b1,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,2'd1,32'h4000,  32'h2002,  32'hBEEF,  1'b0,1'b1,32'hA5A5A5A5, 1'b0,1'b1,2'd1,32'h2002,  32'hBEEF,     1'b0,1'b0,1'b0,1'b1};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b1,2'd1,32'h4000,  32'h2002,  32'hBEEF,  1'b1,1'b1,32'h0,        1'b0,1'b1,2'd1,32'h2002,  32'hBEEF,     1'b0,1'b0,1'b0,1'b0};

    rst = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0; inst_wdata = 32'h11111111;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
    m_rdata = 32'h0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; inst_req = vecs[i].ireq; data_req = vecs[i].dreq;
      data_wr = vecs[i].dwr; data_size = vecs[i].dsize; inst_addr = vecs[i].iaddr;
      data_addr = vecs[i].daddr; data_wdata = vecs[i].dwdata;
      m_addr_ok = vecs[i].maok; m_data_ok = vecs[i].mdok; m_rdata = vecs[i].mrdata;
      @(negedge clk);
      exp_b = {vecs[i].e_req, vecs[i].e_wr, vecs[i].e_size, vecs[i].e_addr, vecs[i].e_wdata,
               vecs[i].e_iaok, vecs[i].e_idok, vecs[i].e_daok, vecs[i].e_ddok,
               vecs[i].mrdata, vecs[i].mrdata};
      check($sformatf("vec%0d", i), observed(), exp_b);
      tick();
    end

    // Both masters saturate the port; slave completes every transaction in one ADDR cycle.
    want = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    got_n = 0;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
    inst_addr = 32'hA000; data_addr = 32'hB000; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0;
    for (int c = 0; c < 40 && got_n < 6; c++) begin
      @(negedge clk);
      if (data_addr_ok) begin order[got_n] = 1'b1; got_n++; end
      else if (inst_addr_ok) begin order[got_n] = 1'b0; got_n++; end
      if (got_n < 6) tick();
    end
    if (got_n < 6) begin
      n_vec++; n_bad++;
      $display("FAIL starve_timeout got=%0d grants exp=6", got_n);
    end else begin
      for (int k = 0; k < 6; k++)
        check($sformatf("starve_grant%0d", k), {135'd0, order[k]}, {135'd0, want[k]});
    end
    tick();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    tick();

    // Reset while a data store is waiting in DATA, then a late m_data_ok.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h5000; data_wdata = 32'h77;
    tick();
    m_addr_ok = 1'b1;
    tick();
    data_req = 1'b0; m_addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("in_data_before_rst", observed(),
          {1'b0, 1'b1, 2'd2, 32'h5000, 32'h77, 4'b0000, 32'h0, 32'h0});
    tick();
    rst = 1'b0; m_data_ok = 1'b1;
    @(negedge clk);
    check("after_rst_late_data_ok", observed(), {136'd0});
    tick();
    m_data_ok = 1'b0;
    @(negedge clk);
    check("after_rst_quiet", observed(), {136'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
